// File: rtl/align_add_if.sv
// Operand/result bus of the binary16 alignment-and-add stage.
// Carries the upstream operand handshake and the downstream result handshake.
// The slave modport is the adder stage; the master modport is its environment.
interface align_add_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  moves;
   logic        swap;
   logic [4:0]  exp;
   logic [9:0]  Am;
   logic [9:0]  Bm;
   logic        sa;
   logic        sb;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] sum;
   logic [2:0]  grs;
   logic [4:0]  exp_out;
   logic        sign_out;
   logic        zero;

   modport slave (
      input  in_valid, moves, swap, exp, Am, Bm, sa, sb, out_ready,
      output in_ready, out_valid, sum, grs, exp_out, sign_out, zero
   );

   modport master (
      output in_valid, moves, swap, exp, Am, Bm, sa, sb, out_ready,
      input  in_ready, out_valid, sum, grs, exp_out, sign_out, zero
   );
endinterface

// File: rtl/align_add.sv
// Binary16 align-and-add: restores hidden bits, shifts smaller significand 1 bit/cycle, adds/subtracts.
// Latency: result valid in cycle n+2 counting the accept cycle as 0 (n = clamped shift, 0..14).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Macro GRS_EN keeps shifted-out bits in grs.
module align_add (
   input  logic       clk,
   input  logic       rst,
   align_add_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ADD, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [13:0] a_ext_q, a_ext_d;
   logic [13:0] b_ext_q, b_ext_d;
   logic [3:0]  n_q, n_d;
   logic        sub_q, sub_d;
   logic        sign_big_q, sign_big_d;
   logic [4:0]  exp_q, exp_d;
   logic [11:0] sum_q, sum_d;
   logic [2:0]  grs_q, grs_d;
   logic        sign_q, sign_d;
   logic        zero_q, zero_d;

   logic [4:0]  sh;
   logic [4:0]  e_small;
   logic        h_a, h_b;
   logic [4:0]  n_raw;
   logic [3:0]  n_clamp;
   logic [14:0] r;
   logic        r_sign;

   // State register; reset abandons any in-flight operation
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: skip SHIFT for aligned operands, leave SHIFT on the last shift cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.in_valid) state_d = (n_clamp != 4'd0) ? S_SHIFT : S_ADD;
         S_SHIFT: if (n_q == 4'd1) state_d = S_ADD;
         S_ADD:   state_d = S_DONE;
         S_DONE:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: handshake from state, result fields straight from registers
   always_comb begin
      bus.in_ready  = (state_q == S_IDLE);
      bus.out_valid = (state_q == S_DONE);
      bus.sum       = sum_q;
      bus.grs       = grs_q;
      bus.exp_out   = exp_q;
      bus.sign_out  = sign_q;
      bus.zero      = zero_q;
   end

   // Datapath: operand setup on accept, sticky right shift, then magnitude add/sub
   always_comb begin
      a_ext_d    = a_ext_q;
      b_ext_d    = b_ext_q;
      n_d        = n_q;
      sub_d      = sub_q;
      sign_big_d = sign_big_q;
      exp_d      = exp_q;
      sum_d      = sum_q;
      grs_d      = grs_q;
      sign_d     = sign_q;
      zero_d     = zero_q;
      r          = 15'd0;
      r_sign     = sign_big_q;

      // Upstream gives A.exp-B.exp; negate it when B was the larger operand
      sh      = bus.swap ? (5'd0 - bus.moves) : bus.moves;
      e_small = bus.exp - sh;
      h_a     = (bus.exp != 5'd0);
      h_b     = (e_small != 5'd0);
      // A subnormal smaller operand sits at exponent 1, one place less to shift
      n_raw   = sh - {4'd0, (e_small == 5'd0) && h_a};
      n_clamp = (n_raw > 5'd14) ? 4'd14 : n_raw[3:0];

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_ext_d    = {h_a, bus.Am, 3'b000};
               b_ext_d    = {h_b, bus.Bm, 3'b000};
               n_d        = n_clamp;
               sub_d      = bus.sa ^ bus.sb;
               sign_big_d = bus.swap ? bus.sb : bus.sa;
               exp_d      = bus.exp;
            end
         end
         S_SHIFT: begin
`ifdef GRS_EN
            b_ext_d = {1'b0, b_ext_q[13:2], b_ext_q[1] | b_ext_q[0]};
`else
            b_ext_d = {1'b0, b_ext_q[13:4], 3'b000};
`endif
            n_d = n_q - 4'd1;
         end
         S_ADD: begin
            if (!sub_q) begin
               r = {1'b0, a_ext_q} + {1'b0, b_ext_q};
            end else if (b_ext_q <= a_ext_q) begin
               r = {1'b0, a_ext_q} - {1'b0, b_ext_q};
            end else begin
               r      = {1'b0, b_ext_q} - {1'b0, a_ext_q};
               r_sign = ~sign_big_q;
            end
            sum_d  = r[14:3];
`ifdef GRS_EN
            grs_d  = r[2:0];
`else
            grs_d  = 3'b000;
`endif
            zero_d = (r == 15'd0);
            sign_d = (r == 15'd0) ? 1'b0 : r_sign;
         end
         default: ;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_ext_q    <= 14'd0;
         b_ext_q    <= 14'd0;
         n_q        <= 4'd0;
         sub_q      <= 1'b0;
         sign_big_q <= 1'b0;
         exp_q      <= 5'd0;
         sum_q      <= 12'd0;
         grs_q      <= 3'd0;
         sign_q     <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         a_ext_q    <= a_ext_d;
         b_ext_q    <= b_ext_d;
         n_q        <= n_d;
         sub_q      <= sub_d;
         sign_big_q <= sign_big_d;
         exp_q      <= exp_d;
         sum_q      <= sum_d;
         grs_q      <= grs_d;
         sign_q     <= sign_d;
         zero_q     <= zero_d;
      end
   end

endmodule

// File: tb/tb_align_add.sv
// Testbench for align_add: directed vectors, scoreboard queue, independent monitor.
// Latency counted in cycles with the accept cycle as cycle 0.
// Exercises backpressure, ignored in_valid outside IDLE, and reset mid-shift.
module tb_align_add;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   typedef struct {
      logic [11:0] sum;
      logic [2:0]  grs;
      logic [4:0]  exp;
      logic        sign;
      logic        zero;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb_q[$];

   align_add_if bus();

   align_add dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!bus.in_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!bus.in_ready) chk("in_ready timeout", {31'd0, bus.in_ready}, 32'd1);
   endtask

   // Issue one operation; expected grs/sum chosen by build option
   task automatic send(input logic [4:0] mv, input logic sw, input logic [4:0] ex,
                       input logic [9:0] am, input logic [9:0] bm, input logic a_s, input logic b_s,
                       input logic [11:0] e_sum_grs, input logic [11:0] e_sum_trunc,
                       input logic [2:0] e_grs, input logic e_sign, input logic e_zero,
                       input int n, input bit push);
      exp_t e;
      wait_ready();
      bus.moves = mv; bus.swap = sw; bus.exp = ex;
      bus.Am = am; bus.Bm = bm; bus.sa = a_s; bus.sb = b_s;
      bus.in_valid = 1'b1;
`ifdef GRS_EN
      e.sum = e_sum_grs;
      e.grs = e_grs;
`else
      e.sum = e_sum_trunc;
      e.grs = 3'b000;
`endif
      e.exp  = ex;
      e.sign = e_sign;
      e.zero = e_zero;
      e.lat  = n + 2;
      e.acc  = cyc;
      if (push) sb_q.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Monitor: latency from rising out_valid, fields compared on each transfer
   bit   mon_prev = 1'b0;
   int   mon_rise = 0;
   exp_t mon_e;
   initial forever begin
      @(negedge clk);
      #1;
      if (rst) begin
         mon_prev = 1'b0;
      end else begin
         if (bus.out_valid && !mon_prev) mon_rise = cyc;
         mon_prev = bus.out_valid;
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected output", {31'd0, bus.out_valid}, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("sum",      {20'd0, bus.sum},      {20'd0, mon_e.sum});
               chk("grs",      {29'd0, bus.grs},      {29'd0, mon_e.grs});
               chk("exp_out",  {27'd0, bus.exp_out},  {27'd0, mon_e.exp});
               chk("sign_out", {31'd0, bus.sign_out}, {31'd0, mon_e.sign});
               chk("zero",     {31'd0, bus.zero},     {31'd0, mon_e.zero});
               chk("latency",  mon_rise - mon_e.acc,  mon_e.lat);
            end
         end
      end
   end

   initial begin
      int k;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.moves = '0; bus.swap = 1'b0; bus.exp = '0;
      bus.Am = '0; bus.Bm = '0; bus.sa = 1'b0; bus.sb = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst sum",       {20'd0, bus.sum},       32'd0);
      chk("rst grs/exp/sign/zero", {23'd0, bus.grs, bus.exp_out, bus.sign_out, bus.zero}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      //   mv     sw  exp    Am      Bm      sa  sb  sum_grs  sum_trunc grs    sign zero n
      send(5'd0,  0, 5'd15, 10'h0,  10'h0,   0,  0, 12'h800, 12'h800, 3'd0, 0, 0, 0,  1); // 1.0+1.0
      send(5'd1,  0, 5'd15, 10'h0,  10'h0,   0,  0, 12'h600, 12'h600, 3'd0, 0, 0, 1,  1); // 1.0+0.5
      send(5'h1F, 1, 5'd15, 10'h0,  10'h0,   0,  1, 12'h200, 12'h200, 3'd0, 1, 0, 1,  1); // 0.5-1.0
      send(5'd0,  0, 5'd15, 10'h0,  10'h0,   0,  1, 12'h000, 12'h000, 3'd0, 0, 1, 0,  1); // 1.0-1.0
      send(5'd14, 0, 5'd15, 10'h0,  10'h1,   0,  0, 12'h400, 12'h400, 3'd1, 0, 0, 14, 1); // max shift
      send(5'd2,  0, 5'd15, 10'h0,  10'h3FF, 0,  0, 12'h5FF, 12'h5FF, 3'd6, 0, 0, 2,  1); // guard/round
      send(5'd0,  0, 5'd15, 10'h0,  10'h200, 0,  1, 12'h200, 12'h200, 3'd0, 1, 0, 0,  1); // B>A flips sign
      send(5'd1,  0, 5'd1,  10'h0,  10'h200, 0,  0, 12'h600, 12'h600, 3'd0, 0, 0, 0,  1); // subnormal B
      send(5'd20, 0, 5'd25, 10'h0,  10'h0,   0,  0, 12'h400, 12'h400, 3'd1, 0, 0, 14, 1); // clamp to 14
      send(5'd2,  0, 5'd15, 10'h0,  10'h3FF, 0,  1, 12'h200, 12'h201, 3'd2, 0, 0, 2,  1); // sub w/ sticky
      send(5'h1E, 1, 5'd15, 10'h100, 10'h0,  1,  0, 12'h400, 12'h400, 3'd0, 0, 0, 2,  1); // swapped sub

      // Backpressure: result held, extra in_valid ignored
      wait_ready();
      bus.out_ready = 1'b0;
      send(5'd0, 0, 5'd15, 10'h0, 10'h0, 0, 0, 12'h800, 12'h800, 3'd0, 0, 0, 0, 1);
      k = 0;
      while (!bus.out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 10; i++) begin
         bus.moves = 5'd3; bus.Am = 10'h155; bus.Bm = 10'h2AA; bus.sb = 1'b1;
         bus.in_valid = 1'b1;
         @(negedge clk);
         chk("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp in_ready",  {31'd0, bus.in_ready},  32'd0);
         chk("bp result",    {11'd0, bus.sum, bus.grs, bus.exp_out, bus.sign_out, bus.zero},
                             {11'd0, 12'h800, 3'd0, 5'd15, 1'b0, 1'b0});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);

      // Reset during SHIFT discards the operation
      send(5'd14, 0, 5'd15, 10'h0, 10'h1, 0, 0, 12'h400, 12'h400, 3'd1, 0, 0, 14, 0);
      repeat (3) @(negedge clk);
      chk("pre-rst in SHIFT", {31'd0, bus.in_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid rst in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("mid rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid rst sum",       {20'd0, bus.sum},       32'd0);
      chk("mid rst exp_out",   {27'd0, bus.exp_out},   32'd0);
      rst = 1'b0;
      @(negedge clk);
      send(5'd1, 0, 5'd15, 10'h0, 10'h0, 0, 0, 12'h600, 12'h600, 3'd0, 0, 0, 1, 1);

      k = 0;
      while (sb_q.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      chk("scoreboard drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
